// File: rtl/sync_dp_ram.sv
// ============================================================================
// sync_dp_ram : single-clock simple-dual-port RAM with byte enables,
//               1/2-cycle registered read, selectable read-during-write and
//               a post-reset clear sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_dp_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_DEPTH   = 64,
    parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_write_en,
    input  logic [ADDR_WIDTH-1:0]            i_write_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_write_be,
    input  logic [DATA_WIDTH-1:0]            i_write_data,
    input  logic                             i_read_en,
    input  logic [ADDR_WIDTH-1:0]            i_read_addr,
    output logic [DATA_WIDTH-1:0]            o_read_data,
    output logic                             o_read_valid,
    output logic                             o_init_busy
);

    localparam int                    c_BE_W  = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DATA_DEPTH - 1);

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
            $error("sync_dp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("sync_dp_ram: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [ADDR_WIDTH-1:0]   w_clr_addr_nxt;
    logic                    w_clr_we;

    logic [DATA_WIDTH-1:0]   r_mem [DATA_DEPTH];

    logic                    w_ready;
    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_clr_we       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_addr == c_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    assign w_ready     = (r_state == ST_READY);
    assign o_init_busy = ~w_ready;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_wr_in_range = ({1'b0, i_write_addr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, i_read_addr} < c_DEPTH);
    assign w_wr_accept   = w_ready & i_write_en & w_wr_in_range;
    assign w_rd_accept   = w_ready & i_read_en;

    // Array has no reset so it can map onto block RAM; the clear
    // sequencer owns the write port until it finishes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_we) begin
                r_mem[r_clr_addr] <= '0;
            end else if (w_wr_accept) begin
                for (int i = 0; i < c_BE_W; i++) begin
                    if (i_write_be[i]) begin
                        r_mem[i_write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                            i_write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Pre-write word, optionally bypassed with the bytes being written.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[i_read_addr];
            if (RDW_MODE == 1 && w_wr_accept && (i_write_addr == i_read_addr)) begin
                for (int i = 0; i < c_BE_W; i++) begin
                    if (i_write_be[i]) begin
                        w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                            i_write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign o_read_valid = r_s2_valid;
            assign o_read_data  = r_s2_data;
        end else begin : g_lat1
            assign o_read_valid = r_s1_valid;
            assign o_read_data  = r_s1_data;
        end
    endgenerate

endmodule

`default_nettype wire
